demux1x2: RTL and testbench
===========================

DEMUX1X2 -- requirements
Module: demux1x2

Interface
REQ-001 Parameter: BW, default 8, data word width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; asserting it clears all state immediately, independent of clk.
REQ-004 Entrada  input  BW  interleaved data word: lane 0 word on even slots, lane 1 word on odd slots.
REQ-005 validEntrada  input  1  qualifies Entrada in the current slot.
REQ-006 Salida0  output  BW  registered lane 0 word of the last completed pair.
REQ-007 Salida1  output  BW  registered lane 1 word of the last completed pair.
REQ-008 validSalida0  output  1  lane 0 word of the last pair was valid.
REQ-009 validSalida1  output  1  lane 1 word of the last pair was valid.
REQ-010 pares  output  8  count of completed pairs with both lanes valid, modulo 256.

Function
REQ-011 Internal slot selector sel (1 bit) shall toggle on every rising edge while reset is low, regardless of validEntrada.
REQ-012 Slot with sel=0 (capture): hold0<=Entrada if validEntrada=1, else 0; hvalid0<=validEntrada; all outputs hold their values.
REQ-013 Slot with sel=1 (emit): Salida0<=hold0, validSalida0<=hvalid0, Salida1<=Entrada if validEntrada=1 else 0, validSalida1<=validEntrada, all in the same edge.
REQ-014 Invalid words shall never reach the outputs: a lane with valid=0 shall present 0 on its data output.
REQ-015 pares shall increment by 1 on an emit edge only when hvalid0=1 and validEntrada=1; 255 shall wrap to 0.
REQ-016 Latency: lane 0 word presented on edge k (sel=0) appears on Salida0 after edge k+1; lane 1 word presented on edge k+1 appears on Salida1 after the same edge k+1.
REQ-017 Outputs shall change only on emit edges: at most every second clock, and both lanes update together.
REQ-018 A lane 0 word captured before reset is asserted shall be discarded; it shall never be paired with a post-reset lane 1 word.
REQ-019 No backpressure: every slot is consumed, and the block has no ready output.

Reset
REQ-020 While reset=1: sel=0, hold0=0, hvalid0=0, Salida0=0, Salida1=0, validSalida0=0, validSalida1=0, pares=0.
REQ-021 After reset deasserts, the first rising edge shall be a capture (sel=0) slot.
REQ-022 Reset asserted mid-pair, e.g. after a capture edge, shall clear state asynchronously within the same cycle, with no output glitch to non-zero values.

Verification
REQ-023 Reset release, then Entrada=8'hA1/valid=1, then 8'hB2/valid=1 -> after the 2nd edge: Salida0=A1, Salida1=B2, both valids=1, pares=1.
REQ-024 Pair A1/valid=1, then 8'hFF/valid=0 -> Salida0=A1, validSalida0=1, Salida1=00, validSalida1=0, pares unchanged.
REQ-025 Stream of 10 words 01..0A, all valid -> outputs update after edges 2,4,...,10 with (01,02),(03,04),...,(09,0A); values held on the odd edges between; pares=5.
REQ-026 256 consecutive fully valid pairs -> pares returns to 0.
REQ-027 Capture 8'h55, then reset pulse between edges, then release, then 8'h11 and 8'h22 valid -> outputs (11,22); 55 never appears; pares=1.
REQ-028 validEntrada=0 for 4 slots with Entrada=8'hEE -> all outputs and valids 0, pares unchanged.

Source files
------------

// File: rtl/demux1x2_if.sv
// Bus bundle for the 1-to-2 lane demultiplexer: interleaved input stream
// and the registered, pair-aligned outputs.
interface demux1x2_if #(
    parameter int BW = 8
);
    // Valid-only flow: a word is consumed in the slot where validEntrada
    // is sampled high; there is no ready, so every slot is taken, and a
    // slot with validEntrada low carries no word.
    logic [BW-1:0] Entrada;
    logic          validEntrada;
    logic [BW-1:0] Salida0;
    logic [BW-1:0] Salida1;
    logic          validSalida0;
    logic          validSalida1;
    logic [7:0]    pares;

    modport master (
        output Entrada, validEntrada,
        input  Salida0, Salida1, validSalida0, validSalida1, pares
    );

    modport slave (
        input  Entrada, validEntrada,
        output Salida0, Salida1, validSalida0, validSalida1, pares
    );
endinterface

// File: rtl/demux1x2.sv
// Splits an interleaved word stream into two lanes: even slots are held,
// odd slots emit the pair on both outputs in the same edge.
module demux1x2 #(
    parameter int BW = 8
) (
    input  logic        clk,
    input  logic        reset,
    demux1x2_if.slave   bus,
    output logic        sel_dbg_o
);

    typedef enum logic {
        SLOT_CAPTURE = 1'b0,
        SLOT_EMIT    = 1'b1
    } slot_e;

    slot_e         state_q, state_d;
    logic [BW-1:0] hold0_q, hold0_d;
    logic          hvalid0_q, hvalid0_d;
    logic [BW-1:0] sal0_q, sal0_d;
    logic [BW-1:0] sal1_q, sal1_d;
    logic          vsal0_q, vsal0_d;
    logic          vsal1_q, vsal1_d;
    logic [7:0]    pares_q, pares_d;
    logic [BW-1:0] word_in;

    // Invalid slots are scrubbed to zero before they can be stored.
    assign word_in = bus.validEntrada ? bus.Entrada : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SLOT_CAPTURE;
            hold0_q   <= '0;
            hvalid0_q <= 1'b0;
            sal0_q    <= '0;
            sal1_q    <= '0;
            vsal0_q   <= 1'b0;
            vsal1_q   <= 1'b0;
            pares_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            hold0_q   <= hold0_d;
            hvalid0_q <= hvalid0_d;
            sal0_q    <= sal0_d;
            sal1_q    <= sal1_d;
            vsal0_q   <= vsal0_d;
            vsal1_q   <= vsal1_d;
            pares_q   <= pares_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold0_d   = hold0_q;
        hvalid0_d = hvalid0_q;
        sal0_d    = sal0_q;
        sal1_d    = sal1_q;
        vsal0_d   = vsal0_q;
        vsal1_d   = vsal1_q;
        pares_d   = pares_q;
        case (state_q)
            SLOT_CAPTURE: begin
                hold0_d   = word_in;
                hvalid0_d = bus.validEntrada;
                state_d   = SLOT_EMIT;
            end
            SLOT_EMIT: begin
                sal0_d  = hold0_q;
                vsal0_d = hvalid0_q;
                sal1_d  = word_in;
                vsal1_d = bus.validEntrada;
                if (hvalid0_q && bus.validEntrada) begin
                    pares_d = pares_q + 8'd1;
                end
                state_d = SLOT_CAPTURE;
            end
            default: state_d = SLOT_CAPTURE;
        endcase
    end

    assign bus.Salida0      = sal0_q;
    assign bus.Salida1      = sal1_q;
    assign bus.validSalida0 = vsal0_q;
    assign bus.validSalida1 = vsal1_q;
    assign bus.pares        = pares_q;
    assign sel_dbg_o        = state_q;

endmodule

// File: tb/tb_demux1x2.sv
// Self-checking bench for demux1x2: directed vector table, reset corner
// sequences and random traffic against a slot-indexed reference model.
module tb_demux1x2;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic reset;
    logic sel_dbg;

    demux1x2_if #(.BW(BW)) bus ();

    demux1x2 #(.BW(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .sel_dbg_o (sel_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic [7:0] exp_s0;
        logic [7:0] exp_s1;
        logic       exp_v0;
        logic       exp_v1;
        logic [7:0] exp_pares;
    } vec_t;

    vec_t vecs[8];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: slots are numbered from reset; even slots supply
    // lane 0, odd slots supply lane 1 and publish the pair.
    int         m_slot;
    logic [7:0] m_lane0;
    logic       m_lane0_v;
    logic [7:0] m_s0, m_s1;
    logic       m_v0, m_v1;
    int         m_pairs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_slot = 0; m_lane0 = 8'h00; m_lane0_v = 1'b0;
        m_s0 = 8'h00; m_s1 = 8'h00; m_v0 = 1'b0; m_v1 = 1'b0; m_pairs = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".Salida0"}, 32'(bus.Salida0), 32'(m_s0));
        check({tag, ".Salida1"}, 32'(bus.Salida1), 32'(m_s1));
        check({tag, ".validSalida0"}, 32'(bus.validSalida0), 32'(m_v0));
        check({tag, ".validSalida1"}, 32'(bus.validSalida1), 32'(m_v1));
        check({tag, ".pares"}, 32'(bus.pares), 32'(m_pairs));
        check({tag, ".sel"}, 32'(sel_dbg), 32'(m_slot % 2));
    endtask

    // Drive one slot, let one rising edge consume it, then compare at +1.
    task automatic apply_slot(input string tag, input logic [7:0] d, input logic v);
        bus.Entrada      = d;
        bus.validEntrada = v;
        @(posedge clk);
        #1;
        if (m_slot % 2 == 0) begin
            m_lane0   = v ? d : 8'h00;
            m_lane0_v = v;
        end else begin
            m_s0 = m_lane0;
            m_v0 = m_lane0_v;
            m_s1 = v ? d : 8'h00;
            m_v1 = v;
            if (m_lane0_v && v) m_pairs = (m_pairs + 1) % 256;
        end
        m_slot++;
        check_model(tag);
    endtask

    // Reset pulse wholly between two rising edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        check({tag, ".rst.Salida0"}, 32'(bus.Salida0), 32'h0);
        check({tag, ".rst.Salida1"}, 32'(bus.Salida1), 32'h0);
        check({tag, ".rst.validSalida0"}, 32'(bus.validSalida0), 32'h0);
        check({tag, ".rst.validSalida1"}, 32'(bus.validSalida1), 32'h0);
        check({tag, ".rst.pares"}, 32'(bus.pares), 32'h0);
        check({tag, ".rst.sel"}, 32'(sel_dbg), 32'h0);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset            = 1'b0;
        bus.Entrada      = '0;
        bus.validEntrada = 1'b0;
        model_reset();

        //            data   v     s0     s1     v0    v1    pares
        vecs[0] = '{8'hA1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{8'hB2, 1'b1, 8'hA1, 8'hB2, 1'b1, 1'b1, 8'd1};
        vecs[2] = '{8'hA1, 1'b1, 8'hA1, 8'hB2, 1'b1, 1'b1, 8'd1};
        vecs[3] = '{8'hFF, 1'b0, 8'hA1, 8'h00, 1'b1, 1'b0, 8'd1};
        vecs[4] = '{8'hEE, 1'b0, 8'hA1, 8'h00, 1'b1, 1'b0, 8'd1};
        vecs[5] = '{8'hEE, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd1};
        vecs[6] = '{8'hEE, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd1};
        vecs[7] = '{8'hEE, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd1};

        #1;
        do_reset("init");

        // Directed pairs: full pair, half-valid pair, idle slots.
        for (int i = 0; i < 8; i++) begin
            apply_slot($sformatf("vec%0d", i), vecs[i].data, vecs[i].valid);
            check($sformatf("tbl%0d.Salida0", i), 32'(bus.Salida0), 32'(vecs[i].exp_s0));
            check($sformatf("tbl%0d.Salida1", i), 32'(bus.Salida1), 32'(vecs[i].exp_s1));
            check($sformatf("tbl%0d.validSalida0", i), 32'(bus.validSalida0), 32'(vecs[i].exp_v0));
            check($sformatf("tbl%0d.validSalida1", i), 32'(bus.validSalida1), 32'(vecs[i].exp_v1));
            check($sformatf("tbl%0d.pares", i), 32'(bus.pares), 32'(vecs[i].exp_pares));
        end

        // Ten-word stream 01..0A: five pairs, held between emit edges.
        do_reset("stream");
        for (int i = 1; i <= 10; i++) apply_slot($sformatf("stream%0d", i), 8'(i), 1'b1);
        check("stream.pares_final", 32'(bus.pares), 32'd5);
        check("stream.last_pair", {16'h0, bus.Salida0, bus.Salida1}, 32'h0000_090A);

        // Stale lane 0 word before a reset pulse must never surface.
        do_reset("discard");
        apply_slot("discard.cap55", 8'h55, 1'b1);
        do_reset("discard.mid");
        apply_slot("discard.s11", 8'h11, 1'b1);
        check("discard.hold_s0", 32'(bus.Salida0), 32'h00);
        apply_slot("discard.s22", 8'h22, 1'b1);
        check("discard.Salida0", 32'(bus.Salida0), 32'h11);
        check("discard.Salida1", 32'(bus.Salida1), 32'h22);
        check("discard.pares", 32'(bus.pares), 32'd1);

        // 256 fully valid pairs wrap the pair counter to zero.
        do_reset("wrap");
        for (int i = 0; i < 512; i++) begin
            apply_slot("wrap", 8'($urandom_range(0, 255)), 1'b1);
            if (i == 509) check("wrap.pares255", 32'(bus.pares), 32'd255);
        end
        check("wrap.pares0", 32'(bus.pares), 32'd0);

        // Random traffic with mixed validity.
        do_reset("rand");
        for (int i = 0; i < 300; i++) begin
            apply_slot("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
        end

        // Reset right after a capture edge while outputs hold a pair.
        if (m_slot % 2 == 0) apply_slot("midpair.cap", 8'h3C, 1'b1);
        do_reset("midpair");
        apply_slot("midpair.after0", 8'h77, 1'b1);
        apply_slot("midpair.after1", 8'h88, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
